// File: rtl/rand_issue_arbiter.sv
// Randomised-start issue arbiter for four requesters competing for one functional unit.
// The LFSR value picks the circular scan start each selection; per-requester age counters
// force a grant to any requester that has waited too long. The winner is registered and
// held under a valid/ready handshake, with back-to-back reselection on handshake.
module rand_issue_arbiter #(
    parameter int unsigned STARVE_LIMIT = 7,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] random_number,
    input  logic [3:0] req,
    input  logic       grant_ready,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic [3:0] grant_onehot,
    output logic       starve_hit
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    state_e           state_q;
    logic [CNT_W-1:0] age_q [4];
    logic [CNT_W-1:0] age_d [4];

    logic       handshake;
    logic       sel_en;
    logic [3:0] cand;
    logic [3:0] starve_vec;
    logic       starve_any;
    logic [1:0] starve_idx;
    logic       rr_found;
    logic [1:0] rr_idx;
    logic [1:0] scan_pos;
    logic       win_valid;
    logic [1:0] win_idx;
    logic [3:0] win_onehot;

    assign handshake = grant_valid & grant_ready;
    assign sel_en    = (state_q == StIdle) | handshake;

    // Candidates: the requester completing its handshake cannot win again the same cycle.
    assign cand = req & ~(handshake ? grant_onehot : 4'b0000);

    // Starvation override: lowest-index candidate whose age has reached the limit.
    always_comb begin
        starve_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            starve_vec[i] = cand[i] & (age_q[i] >= Limit);
        end
        for (int i = 3; i >= 0; i--) begin
            if (starve_vec[i]) begin
                starve_idx = 2'(i);
            end
        end
        starve_any = |starve_vec;
    end

    // Circular scan starting at random_number; 2-bit arithmetic wraps mod 4.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = random_number;
        scan_pos = random_number;
        for (int k = 0; k < 4; k++) begin
            scan_pos = random_number + 2'(k);
            if (!rr_found && cand[scan_pos]) begin
                rr_found = 1'b1;
                rr_idx   = scan_pos;
            end
        end
    end

    // Final winner: override beats random scan.
    always_comb begin
        win_valid  = |cand;
        win_idx    = starve_any ? starve_idx : rr_idx;
        win_onehot = 4'b0001 << win_idx;
    end

    // Age next-state: clear on idle request or own handshake, freeze while held, else saturate up.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_q[i];
            if (!req[i] || (handshake && grant_idx == 2'(i))) begin
                age_d[i] = '0;
            end else if (grant_valid && grant_idx == 2'(i)) begin
                age_d[i] = age_q[i];
            end else if (age_q[i] < Limit) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // Age counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Grant FSM with registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            grant_valid  <= 1'b0;
            grant_idx    <= 2'd0;
            grant_onehot <= 4'b0000;
            starve_hit   <= 1'b0;
        end else begin
            starve_hit <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (sel_en && win_valid) begin
                        state_q      <= StHold;
                        grant_valid  <= 1'b1;
                        grant_idx    <= win_idx;
                        grant_onehot <= win_onehot;
                        starve_hit   <= starve_any;
                    end
                end
                StHold: begin
                    if (handshake) begin
                        if (win_valid) begin
                            grant_idx    <= win_idx;
                            grant_onehot <= win_onehot;
                            starve_hit   <= starve_any;
                        end else begin
                            state_q      <= StIdle;
                            grant_valid  <= 1'b0;
                            grant_onehot <= 4'b0000;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    grant_valid  <= 1'b0;
                    grant_onehot <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_issue_arbiter.sv
// Directed bench for rand_issue_arbiter built with a starvation limit of 3.
module tb_rand_issue_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] random_number;
    logic [3:0] req;
    logic       grant_ready;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;
    logic       starve_hit;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rand_issue_arbiter #(
        .STARVE_LIMIT(3),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .random_number(random_number),
        .req          (req),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .starve_hit   (starve_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [1:0] exp_idx [5];
    logic       exp_sh  [5];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr           = 1'b1;
        random_number = 2'd0;
        req           = 4'b0000;
        grant_ready   = 1'b0;
        #12;
        check("rst_valid", grant_valid, 0);
        check("rst_idx", grant_idx, 0);
        check("rst_onehot", grant_onehot, 0);
        check("rst_starve", starve_hit, 0);
        @(posedge clk);
        #1 clr = 1'b0;

        // Random start point, then wrap-around on back-to-back reselection.
        req = 4'b1111; random_number = 2'd2; grant_ready = 1'b1;
        tick();
        check("rs_valid", grant_valid, 1);
        check("rs_idx", grant_idx, 2);
        check("rs_onehot", grant_onehot, 4'b0100);
        check("rs_starve", starve_hit, 0);
        req = 4'b0011; random_number = 2'd3;
        tick();
        check("wrap_valid", grant_valid, 1);
        check("wrap_idx", grant_idx, 0);
        check("wrap_onehot", grant_onehot, 4'b0001);
        req = 4'b0000;
        tick();
        check("rs_idle_valid", grant_valid, 0);
        check("rs_idle_onehot", grant_onehot, 0);

        // Hold stability while not ready.
        req = 4'b1010; random_number = 2'd1; grant_ready = 1'b0;
        tick();
        check("hold_first_idx", grant_idx, 1);
        for (int k = 0; k < 5; k++) begin
            random_number = 2'(k + 2);
            req = 4'b1000;
            tick();
            check("hold_idx", grant_idx, 1);
            check("hold_valid", grant_valid, 1);
            check("hold_onehot", grant_onehot, 4'b0010);
        end
        grant_ready = 1'b1; req = 4'b0000;
        tick();
        check("hold_release_valid", grant_valid, 0);

        // Back-to-back grants with no bubble.
        req = 4'b0101; random_number = 2'd0; grant_ready = 1'b1;
        tick();
        check("b2b_idx0", grant_idx, 0);
        check("b2b_valid0", grant_valid, 1);
        tick();
        check("b2b_idx1", grant_idx, 2);
        check("b2b_valid1", grant_valid, 1);
        req = 4'b0000;
        tick();
        check("b2b_end_valid", grant_valid, 0);

        // Asynchronous reset in the middle of a hold.
        req = 4'b0001; grant_ready = 1'b0;
        tick();
        check("pre_rst_valid", grant_valid, 1);
        #1 clr = 1'b1; req = 4'b0000;
        #1;
        check("async_rst_valid", grant_valid, 0);
        check("async_rst_onehot", grant_onehot, 0);
        check("async_rst_idx", grant_idx, 0);
        @(posedge clk);
        #1 clr = 1'b0;
        tick();
        tick();
        check("post_rst_valid", grant_valid, 0);

        // No requests: ready toggling must not create grants.
        for (int k = 0; k < 10; k++) begin
            req = 4'b0000;
            grant_ready = k[0];
            tick();
            check("idle_valid", grant_valid, 0);
            check("idle_onehot", grant_onehot, 0);
        end

        // Starvation: requester 3 loses the random scan until its age reaches 3.
        exp_idx[0] = 2'd0; exp_sh[0] = 1'b0;
        exp_idx[1] = 2'd1; exp_sh[1] = 1'b0;
        exp_idx[2] = 2'd0; exp_sh[2] = 1'b0;
        exp_idx[3] = 2'd3; exp_sh[3] = 1'b1;
        exp_idx[4] = 2'd0; exp_sh[4] = 1'b0;
        req = 4'b1011; random_number = 2'd0; grant_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("starve_idx", grant_idx, exp_idx[k]);
            check("starve_hit", starve_hit, exp_sh[k]);
            check("starve_valid", grant_valid, 1);
        end
        req = 4'b0000;
        tick();
        check("starve_end_valid", grant_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
